// File: rtl/fft_frame_feeder.sv
// ADC front-end for the 256-point FFT input buffer: offset-binary to two's complement,
// block-average decimation, rising-edge level trigger with auto-timeout, frame write-out.
module fft_frame_feeder #(
    parameter int unsigned ADC_WIDTH    = 12,
    parameter int unsigned DATA_WIDTH   = 12,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned TRIG_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADC_WIDTH-1:0]  adc_data,
    input  logic                  adc_valid,
    input  logic [2:0]            dec_shift,
    input  logic                  trig_en,
    input  logic [DATA_WIDTH-1:0] trig_level,
    input  logic                  s_axis_data_tready,
    output logic [DATA_WIDTH-1:0] fft_data_in,
    output logic [ADDR_WIDTH-1:0] fft_addr_in,
    output logic                  fft_data_in_en,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  trig_timeout,
    output logic                  overrun
);

    localparam int unsigned ACC_WIDTH = DATA_WIDTH + 7;
    localparam int unsigned TO_WIDTH  = $clog2(TRIG_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_TRIG,
        CAPTURE,
        DONE_WAIT
    } state_t;

    state_t state_q, state_d;

    // Stage 1: inverting the MSB turns offset-binary into two's complement
    logic signed [ADC_WIDTH-1:0]  s_raw;
    logic signed [DATA_WIDTH-1:0] s_q;
    logic                         s_v_q;

    assign s_raw = {~adc_data[ADC_WIDTH-1], adc_data[ADC_WIDTH-2:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q   <= '0;
            s_v_q <= 1'b0;
        end else begin
            s_q   <= DATA_WIDTH'(s_raw);
            s_v_q <= adc_valid;
        end
    end

    // Stage 2: decimator
    logic [2:0]                   dec_shift_q;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic signed [ACC_WIDTH-1:0]  acc_sum;
    logic [6:0]                   dec_cnt_q;
    logic [6:0]                   dec_last;
    logic                         dec_valid_q;
    logic signed [DATA_WIDTH-1:0] dec_sample_q;

    assign acc_sum  = acc_q + ACC_WIDTH'(s_q);
    assign dec_last = 7'((8'd1 << dec_shift_q) - 8'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_shift_q  <= '0;
            acc_q        <= '0;
            dec_cnt_q    <= '0;
            dec_valid_q  <= 1'b0;
            dec_sample_q <= '0;
        end else if (state_q == ARM) begin
            dec_shift_q <= dec_shift;
            acc_q       <= '0;
            dec_cnt_q   <= '0;
            dec_valid_q <= 1'b0;
        end else begin
            dec_valid_q <= 1'b0;
            if (s_v_q) begin
                if (dec_cnt_q == dec_last) begin
                    dec_sample_q <= DATA_WIDTH'(acc_sum >>> dec_shift_q);
                    dec_valid_q  <= 1'b1;
                    acc_q        <= '0;
                    dec_cnt_q    <= '0;
                end else begin
                    acc_q     <= acc_sum;
                    dec_cnt_q <= dec_cnt_q + 7'd1;
                end
            end
        end
    end

    // Frame control
    logic signed [DATA_WIDTH-1:0] prev_q, prev_d;
    logic                         prev_valid_q, prev_valid_d;
    logic [TO_WIDTH-1:0]          to_cnt_q, to_cnt_d;
    logic [ADDR_WIDTH-1:0]        wr_cnt_q, wr_cnt_d;
    logic                         trig_timeout_q, trig_timeout_d;
    logic                         overrun_q, overrun_d;
    logic [DATA_WIDTH-1:0]        fft_data_q, fft_data_d;
    logic [ADDR_WIDTH-1:0]        fft_addr_q, fft_addr_d;
    logic                         fft_en_q, fft_en_d;
    logic                         frame_done_q, frame_done_d;
    logic                         lvl_hit, to_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            prev_q         <= '0;
            prev_valid_q   <= 1'b0;
            to_cnt_q       <= '0;
            wr_cnt_q       <= '0;
            trig_timeout_q <= 1'b0;
            overrun_q      <= 1'b0;
            fft_data_q     <= '0;
            fft_addr_q     <= '0;
            fft_en_q       <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            prev_q         <= prev_d;
            prev_valid_q   <= prev_valid_d;
            to_cnt_q       <= to_cnt_d;
            wr_cnt_q       <= wr_cnt_d;
            trig_timeout_q <= trig_timeout_d;
            overrun_q      <= overrun_d;
            fft_data_q     <= fft_data_d;
            fft_addr_q     <= fft_addr_d;
            fft_en_q       <= fft_en_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign lvl_hit = prev_valid_q && (prev_q < $signed(trig_level))
                     && (dec_sample_q >= $signed(trig_level));
    assign to_hit  = (to_cnt_q == TO_WIDTH'(TRIG_TIMEOUT - 1));

    always_comb begin
        state_d        = state_q;
        prev_d         = prev_q;
        prev_valid_d   = prev_valid_q;
        to_cnt_d       = to_cnt_q;
        wr_cnt_d       = wr_cnt_q;
        trig_timeout_d = trig_timeout_q;
        overrun_d      = overrun_q;
        fft_data_d     = fft_data_q;
        fft_addr_d     = fft_addr_q;
        fft_en_d       = 1'b0;
        // Pulse lands the cycle after the last-address strobe
        frame_done_d   = fft_en_q && (fft_addr_q == '1);

        case (state_q)
            IDLE: begin
                if (s_axis_data_tready) state_d = ARM;
            end
            ARM: begin
                prev_valid_d   = 1'b0;
                to_cnt_d       = '0;
                trig_timeout_d = 1'b0;
                overrun_d      = 1'b0;
                state_d        = WAIT_TRIG;
            end
            WAIT_TRIG: begin
                if (dec_valid_q) begin
                    if (!trig_en || lvl_hit || to_hit) begin
                        // Flag only frames that were forced, not genuine crossings
                        if (trig_en && !lvl_hit) trig_timeout_d = 1'b1;
                        fft_en_d   = 1'b1;
                        fft_data_d = dec_sample_q;
                        fft_addr_d = '0;
                        wr_cnt_d   = ADDR_WIDTH'(1);
                        state_d    = CAPTURE;
                    end else begin
                        prev_d       = dec_sample_q;
                        prev_valid_d = 1'b1;
                        to_cnt_d     = to_cnt_q + TO_WIDTH'(1);
                    end
                end
            end
            CAPTURE: begin
                if (dec_valid_q) begin
                    if (s_axis_data_tready) begin
                        fft_en_d   = 1'b1;
                        fft_data_d = dec_sample_q;
                        fft_addr_d = wr_cnt_q;
                        wr_cnt_d   = wr_cnt_q + ADDR_WIDTH'(1);
                        if (wr_cnt_q == '1) state_d = DONE_WAIT;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            DONE_WAIT: begin
                if (!s_axis_data_tready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign fft_data_in    = fft_data_q;
    assign fft_addr_in    = fft_addr_q;
    assign fft_data_in_en = fft_en_q;
    assign busy           = (state_q != IDLE);
    assign frame_done     = frame_done_q;
    assign trig_timeout   = trig_timeout_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed bench for fft_frame_feeder: queue-based reference model compared every cycle,
// plus hand-computed literal expectations per scenario.
module tb_fft_frame_feeder;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] adc_data = '0;
    logic        adc_valid = 1'b0;
    logic [2:0]  dec_shift = '0;
    logic        trig_en = 1'b0;
    logic [11:0] trig_level = '0;
    logic        s_axis_data_tready = 1'b0;
    logic [11:0] fft_data_in;
    logic [7:0]  fft_addr_in;
    logic        fft_data_in_en;
    logic        busy;
    logic        frame_done;
    logic        trig_timeout;
    logic        overrun;

    fft_frame_feeder #(
        .ADC_WIDTH(12),
        .DATA_WIDTH(12),
        .ADDR_WIDTH(8),
        .TRIG_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .adc_data(adc_data),
        .adc_valid(adc_valid),
        .dec_shift(dec_shift),
        .trig_en(trig_en),
        .trig_level(trig_level),
        .s_axis_data_tready(s_axis_data_tready),
        .fft_data_in(fft_data_in),
        .fft_addr_in(fft_addr_in),
        .fft_data_in_en(fft_data_in_en),
        .busy(busy),
        .frame_done(frame_done),
        .trig_timeout(trig_timeout),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model
    typedef enum {M_IDLE, M_ARM, M_WAIT, M_CAP, M_DONE} mmode_t;
    mmode_t m_mode = M_IDLE;
    int m_s = 0;
    bit m_sv = 0;
    int m_q[$];
    int m_shift = 0;
    bit m_dv = 0;
    int m_ds = 0;
    int m_prev = 0;
    bit m_has_prev = 0;
    int m_waited = 0;
    int m_next = 0;
    bit m_done_pend = 0;
    bit e_en = 0, e_done = 0, e_to = 0, e_ovr = 0;
    int e_addr = 0, e_data = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = M_IDLE; m_s = 0; m_sv = 0; m_q.delete(); m_shift = 0;
            m_dv = 0; m_ds = 0; m_prev = 0; m_has_prev = 0; m_waited = 0;
            m_next = 0; m_done_pend = 0;
            e_en = 0; e_done = 0; e_to = 0; e_ovr = 0; e_addr = 0; e_data = 0;
        end else begin
            mmode_t nm;
            int lvl;
            bit by_level, by_time;
            int acc;
            nm = m_mode;
            e_done = m_done_pend;
            m_done_pend = 0;
            e_en = 0;
            case (m_mode)
                M_IDLE: if (s_axis_data_tready) nm = M_ARM;
                M_ARM: begin
                    m_has_prev = 0; m_waited = 0; e_to = 0; e_ovr = 0; nm = M_WAIT;
                end
                M_WAIT: if (m_dv) begin
                    lvl = int'($signed(trig_level));
                    by_level = m_has_prev && (m_prev < lvl) && (m_ds >= lvl);
                    by_time = (m_waited == TO - 1);
                    if (!trig_en || by_level || by_time) begin
                        if (trig_en && !by_level) e_to = 1;
                        e_en = 1; e_addr = 0; e_data = m_ds; m_next = 1; nm = M_CAP;
                    end else begin
                        m_prev = m_ds; m_has_prev = 1; m_waited++;
                    end
                end
                M_CAP: if (m_dv) begin
                    if (s_axis_data_tready) begin
                        e_en = 1; e_addr = m_next; e_data = m_ds;
                        if (m_next == 255) begin
                            nm = M_DONE; m_done_pend = 1;
                        end
                        m_next++;
                    end else begin
                        e_ovr = 1;
                    end
                end
                M_DONE: if (!s_axis_data_tready) nm = M_IDLE;
                default: nm = M_IDLE;
            endcase
            m_dv = 0;
            if (m_mode == M_ARM) begin
                m_q.delete();
                m_shift = int'(dec_shift);
            end else if (m_sv) begin
                m_q.push_back(m_s);
                if (m_q.size() == (1 << m_shift)) begin
                    acc = 0;
                    foreach (m_q[i]) acc += m_q[i];
                    m_ds = acc >>> m_shift;
                    m_dv = 1;
                    m_q.delete();
                end
            end
            m_s = int'(adc_data) - 2048;
            m_sv = adc_valid;
            m_mode = nm;
        end
    end

    always @(negedge clk) begin
        check("strobe", int'(fft_data_in_en), int'(e_en));
        check("addr", int'(fft_addr_in), e_addr);
        check("data", int'(fft_data_in), e_data & 32'hFFF);
        check("frame_done", int'(frame_done), int'(e_done));
        check("busy", int'(busy), int'(m_mode != M_IDLE));
        check("trig_timeout", int'(trig_timeout), int'(e_to));
        check("overrun", int'(overrun), int'(e_ovr));
    end

    // Frame log taken from the write port
    int cyc = 0;
    int strobe_cnt = 0;
    int done_seen = 0;
    int t_addr0 = 0, t_addr1 = 0, first_cyc = 0;
    int log_mem[256];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (fft_data_in_en) begin
            log_mem[fft_addr_in] = int'($signed(fft_data_in));
            strobe_cnt++;
            if (fft_addr_in == 8'd0) t_addr0 = cyc;
            if (fft_addr_in == 8'd1) t_addr1 = cyc;
        end
        if (frame_done) done_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input bit ten, input int lvl, input int sh);
        trig_en = ten;
        trig_level = 12'(lvl);
        dec_shift = 3'(sh);
        strobe_cnt = 0;
        done_seen = 0;
        s_axis_data_tready = 1'b1;
        tick();
        tick();
    endtask

    task automatic feed_ramp(input int first, input int n);
        for (int k = 0; k < n; k++) begin
            adc_data = 12'(first + k);
            adc_valid = 1'b1;
            tick();
            if (k == 0) first_cyc = cyc;
        end
        adc_valid = 1'b0;
    endtask

    task automatic feed_sine(input int n);
        int tbl[8] = '{0, 1447, 2047, 1447, 0, -1447, -2047, -1447};
        for (int k = 0; k < n; k++) begin
            adc_data = 12'(2048 + tbl[k % 8]);
            adc_valid = 1'b1;
            tick();
        end
        adc_valid = 1'b0;
    endtask

    task automatic finish_frame(input string name);
        int w;
        w = 0;
        while (done_seen == 0 && w < 50) begin tick(); w++; end
        check({name, " frame_done seen"}, done_seen, 1);
        check({name, " strobe count"}, strobe_cnt, 256);
        s_axis_data_tready = 1'b0;
        w = 0;
        while (busy && w < 10) begin tick(); w++; end
        check({name, " back to idle"}, int'(busy), 0);
        tick();
        tick();
    endtask

    task automatic wait_addr(input int a);
        int w;
        w = 0;
        while (!(fft_data_in_en && fft_addr_in == 8'(a)) && w < 2000) begin tick(); w++; end
        check("wait for addr strobe", int'(fft_addr_in), a);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset strobe", int'(fft_data_in_en), 0);
        check("reset addr", int'(fft_addr_in), 0);
        check("reset busy", int'(busy), 0);
        tick();

        // Free-run ramp, no decimation
        start_frame(1'b0, 0, 0);
        feed_ramp(2048, 256);
        finish_frame("freerun");
        check("freerun data[0]", log_mem[0], 0);
        check("freerun data[128]", log_mem[128], 128);
        check("freerun data[255]", log_mem[255], 255);
        check("freerun latency", t_addr0 - first_cyc, 2);

        // Decimation by 4 of a constant
        start_frame(1'b0, 0, 2);
        feed_ramp(12'hC00, 1);
        adc_data = 12'hC00;
        for (int k = 0; k < 1030; k++) begin adc_valid = 1'b1; tick(); end
        adc_valid = 1'b0;
        finish_frame("decim");
        check("decim data[0]", log_mem[0], 12'h400);
        check("decim data[255]", log_mem[255], 12'h400);
        check("decim spacing", t_addr1 - t_addr0, 4);
        check("decim latency", t_addr0 - first_cyc, 5);

        // Level trigger on a sine: first sample equals the level but has no predecessor
        start_frame(1'b1, 0, 0);
        feed_sine(280);
        finish_frame("level");
        check("level data[0]", log_mem[0], 0);
        check("level data[1]", log_mem[1], 1447);
        check("level data[2]", log_mem[2], 2047);
        check("level trig_timeout", int'(trig_timeout), 0);

        // Auto-trigger: ramp stays below the level
        start_frame(1'b1, 100, 0);
        feed_ramp(2048 - 1000, 272);
        finish_frame("timeout");
        check("timeout data[0]", log_mem[0], -985);
        check("timeout data[1]", log_mem[1], -984);
        check("timeout trig_timeout", int'(trig_timeout), 1);

        // Back-pressure for three sample periods mid-capture
        start_frame(1'b0, 0, 0);
        fork
            feed_ramp(2048, 270);
            begin
                wait_addr(50);
                s_axis_data_tready = 1'b0;
                tick(); tick(); tick();
                s_axis_data_tready = 1'b1;
            end
        join
        finish_frame("overrun");
        check("overrun flag", int'(overrun), 1);
        check("overrun data[50]", log_mem[50], 50);
        check("overrun data[51]", log_mem[51], 54);
        check("overrun data[255]", log_mem[255], 258);

        // Reset at address 100
        start_frame(1'b0, 0, 0);
        fork
            feed_ramp(2048, 300);
            begin
                wait_addr(20);
                s_axis_data_tready = 1'b0;
                tick();
                s_axis_data_tready = 1'b1;
                wait_addr(100);
                check("pre-reset overrun", int'(overrun), 1);
                rst = 1'b1;
                @(negedge clk);
                check("mid-reset strobe", int'(fft_data_in_en), 0);
                check("mid-reset addr", int'(fft_addr_in), 0);
                check("mid-reset data", int'(fft_data_in), 0);
                check("mid-reset busy", int'(busy), 0);
                check("mid-reset overrun", int'(overrun), 0);
                s_axis_data_tready = 1'b0;
                tick();
                tick();
                rst = 1'b0;
            end
        join
        tick();
        start_frame(1'b0, 0, 0);
        feed_ramp(2048, 256);
        finish_frame("after reset");
        check("after reset data[0]", log_mem[0], 0);
        check("after reset data[255]", log_mem[255], 255);
        check("after reset overrun", int'(overrun), 0);
        check("after reset trig_timeout", int'(trig_timeout), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
